// File: rtl/screen_scanout.sv
// Hack 512x256 monochrome screen to 3-bit VGA colour. Three-clock pipeline:
// address/window decode, RAM read, colour select; syncs ride alongside.
module screen_scanout #(
  parameter int   X_OFF     = 64,
  parameter int   Y_OFF     = 112,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic [9:0]  counter_x,
  input  logic [9:0]  counter_y,
  input  logic        in_display_area,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  fg_color,
  input  logic [2:0]  bg_color,
  input  logic [2:0]  border_color,
  input  logic        enable,
  output logic [12:0] scr_addr,
  output logic        scr_rd_en,
  input  logic [15:0] scr_data,
  output logic [2:0]  pix,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  localparam logic [10:0] X_LO = 11'(X_OFF);
  localparam logic [10:0] X_HI = 11'(X_OFF + 511);
  localparam logic [10:0] Y_LO = 11'(Y_OFF);
  localparam logic [10:0] Y_HI = 11'(Y_OFF + 255);

  logic [10:0] cx, cy;
  logic        in_win, at_origin;
  logic [8:0]  x_rel;
  logic [7:0]  y_rel;

  // index 0 = stage 1, index 1 = stage 2
  logic [1:0]       de_pipe, win_pipe, hs_pipe, vs_pipe;
  logic [1:0][3:0]  bit_pipe;

  logic [2:0] fg_sh, bg_sh, border_sh;
  logic       en_sh;
  logic [2:0] pix_next;

  assign cx        = {1'b0, counter_x};
  assign cy        = {1'b0, counter_y};
  assign in_win    = in_display_area && (cx >= X_LO) && (cx <= X_HI)
                                     && (cy >= Y_LO) && (cy <= Y_HI);
  assign x_rel     = 9'(counter_x - 10'(X_OFF));
  assign y_rel     = 8'(counter_y - 10'(Y_OFF));
  assign at_origin = (counter_x == 10'd0) && (counter_y == 10'd0);

  // bit 0 of a word is the leftmost pixel, so the column nibble indexes directly
  always_comb begin
    pix_next = 3'b000;
    if (!de_pipe[1])                   pix_next = 3'b000;
    else if (!win_pipe[1])             pix_next = border_sh;
    else if (!en_sh)                   pix_next = bg_sh;
    else if (scr_data[bit_pipe[1]])    pix_next = fg_sh;
    else                               pix_next = bg_sh;
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      scr_addr    <= '0;
      scr_rd_en   <= 1'b0;
      de_pipe     <= '0;
      win_pipe    <= '0;
      hs_pipe     <= {2{SYNC_IDLE}};
      vs_pipe     <= {2{SYNC_IDLE}};
      bit_pipe    <= '0;
      pix         <= 3'b000;
      hsync_out   <= SYNC_IDLE;
      vsync_out   <= SYNC_IDLE;
      frame_start <= 1'b0;
      fg_sh       <= 3'b111;
      bg_sh       <= 3'b000;
      border_sh   <= 3'b000;
      en_sh       <= 1'b0;
    end else begin
      scr_rd_en <= in_win;
      if (in_win) scr_addr <= {y_rel, x_rel[8:4]};
      de_pipe   <= {de_pipe[0], in_display_area};
      win_pipe  <= {win_pipe[0], in_win};
      hs_pipe   <= {hs_pipe[0], hsync_in};
      vs_pipe   <= {vs_pipe[0], vsync_in};
      bit_pipe  <= {bit_pipe[0], x_rel[3:0]};

      pix       <= pix_next;
      hsync_out <= hs_pipe[1];
      vsync_out <= vs_pipe[1];

      // colours/enable are latched once per frame so mid-frame writes never tear
      frame_start <= at_origin;
      if (at_origin) begin
        fg_sh     <= fg_color;
        bg_sh     <= bg_color;
        border_sh <= border_color;
        en_sh     <= enable;
      end
    end
  end

endmodule

// File: tb/tb_screen_scanout.sv
// Directed bench for screen_scanout: table-driven raster samples with a
// behavioural synchronous RAM, plus shadow-timing and mid-frame reset checks.
module tb_screen_scanout;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic [9:0]  counter_x, counter_y;
  logic        in_display_area, hsync_in, vsync_in;
  logic [2:0]  fg_color, bg_color, border_color;
  logic        enable;
  logic [12:0] scr_addr;
  logic        scr_rd_en;
  logic [15:0] scr_data;
  logic [2:0]  pix;
  logic        hsync_out, vsync_out, frame_start;

  logic [15:0] mem [0:8191];
  int checks = 0;
  int errors = 0;

  screen_scanout dut (
    .clk50(clk50), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .fg_color(fg_color), .bg_color(bg_color), .border_color(border_color),
    .enable(enable), .scr_addr(scr_addr), .scr_rd_en(scr_rd_en),
    .scr_data(scr_data), .pix(pix), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .frame_start(frame_start)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) if (scr_rd_en) scr_data <= mem[scr_addr];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50); #1;
  endtask

  task automatic drive(input int x, input int y, input logic de);
    counter_x = 10'(x); counter_y = 10'(y); in_display_area = de;
  endtask

  typedef struct {
    int         cx, cy;
    logic       de, hs, vs;
    logic [2:0] pix;
    logic       rd;
    int         addr;
    logic       fs;
  } vec_t;

  vec_t v [13];

  initial begin
    // shadows at first frame start: fg=010 bg=001 border=100 en=1
    v[0]  = '{cx:0,   cy:0,   de:0, hs:1, vs:1, pix:3'b000, rd:0, addr:0,    fs:1};
    v[1]  = '{cx:81,  cy:115, de:1, hs:1, vs:1, pix:3'b010, rd:1, addr:97,   fs:0};
    v[2]  = '{cx:80,  cy:115, de:1, hs:1, vs:1, pix:3'b001, rd:1, addr:97,   fs:0};
    v[3]  = '{cx:63,  cy:115, de:1, hs:1, vs:1, pix:3'b100, rd:0, addr:97,   fs:0};
    v[4]  = '{cx:10,  cy:10,  de:1, hs:1, vs:1, pix:3'b100, rd:0, addr:97,   fs:0};
    v[5]  = '{cx:100, cy:115, de:0, hs:0, vs:1, pix:3'b000, rd:0, addr:97,   fs:0};
    v[6]  = '{cx:100, cy:115, de:0, hs:1, vs:0, pix:3'b000, rd:0, addr:97,   fs:0};
    v[7]  = '{cx:575, cy:367, de:1, hs:1, vs:1, pix:3'b010, rd:1, addr:8191, fs:0};
    v[8]  = '{cx:576, cy:367, de:1, hs:1, vs:1, pix:3'b100, rd:0, addr:8191, fs:0};
    v[9]  = '{cx:575, cy:368, de:1, hs:1, vs:1, pix:3'b100, rd:0, addr:8191, fs:0};
    v[10] = '{cx:64,  cy:112, de:1, hs:1, vs:1, pix:3'b001, rd:1, addr:0,    fs:0};
    v[11] = '{cx:0,   cy:1,   de:0, hs:1, vs:1, pix:3'b000, rd:0, addr:0,    fs:0};
    v[12] = '{cx:0,   cy:1,   de:0, hs:1, vs:1, pix:3'b000, rd:0, addr:0,    fs:0};

    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[97]   = 16'h0002;
    mem[8191] = 16'h8000;
    scr_data  = 16'h0000;

    // reset: syncs driven low so the idle-high outputs come from reset alone
    rst_n = 1'b0; drive(0, 0, 1'b0); hsync_in = 1'b0; vsync_in = 1'b0;
    fg_color = 3'b010; bg_color = 3'b001; border_color = 3'b100; enable = 1'b1;
    step(); step();
    check("rst_pix", 16'(pix), 16'h0);
    check("rst_rd", 16'(scr_rd_en), 16'h0);
    check("rst_addr", 16'(scr_addr), 16'h0);
    check("rst_hs", 16'(hsync_out), 16'h1);
    check("rst_vs", 16'(vsync_out), 16'h1);
    check("rst_fs", 16'(frame_start), 16'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(v[i].cx, v[i].cy, v[i].de);
      hsync_in = v[i].hs; vsync_in = v[i].vs;
      step();
      check($sformatf("v%0d_rd", i), 16'(scr_rd_en), 16'(v[i].rd));
      check($sformatf("v%0d_addr", i), 16'(scr_addr), 16'(v[i].addr));
      check($sformatf("v%0d_fs", i), 16'(frame_start), 16'(v[i].fs));
      if (i >= 2) begin
        check($sformatf("v%0d_pix", i - 2), 16'(pix), 16'(v[i-2].pix));
        check($sformatf("v%0d_hs", i - 2), 16'(hsync_out), 16'(v[i-2].hs));
        check($sformatf("v%0d_vs", i - 2), 16'(vsync_out), 16'(v[i-2].vs));
      end
    end

    // mid-frame colour change stays invisible until the next frame start
    fg_color = 3'b111;
    drive(81, 200, 1'b1); step();
    drive(81, 115, 1'b1); step(); step(); step();
    check("shadow_old_fg", 16'(pix), 16'h2);
    drive(0, 0, 1'b0); step();
    check("shadow_fs", 16'(frame_start), 16'h1);
    drive(81, 115, 1'b1); step();
    check("shadow_fs_once", 16'(frame_start), 16'h0);
    step(); step();
    check("shadow_new_fg", 16'(pix), 16'h7);

    // mid-frame reset flushes outputs; window shows reset bg until frame start
    rst_n = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    step();
    check("mrst_pix", 16'(pix), 16'h0);
    check("mrst_rd", 16'(scr_rd_en), 16'h0);
    check("mrst_addr", 16'(scr_addr), 16'h0);
    check("mrst_hs", 16'(hsync_out), 16'h1);
    rst_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    step();
    check("mrst_rd_after", 16'(scr_rd_en), 16'h1);
    step(); step();
    check("mrst_bg", 16'(pix), 16'h0);
    drive(0, 0, 1'b0); step();
    check("mrst_fs", 16'(frame_start), 16'h1);
    drive(81, 115, 1'b1); step(); step(); step();
    check("mrst_fg", 16'(pix), 16'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
